// File: rtl/gpio_seq_pkg.sv
// gpio_seq_pkg: register map, bit indices and FSM states for the GPIO pulse sequencer
package gpio_seq_pkg;
  localparam logic [2:0] ADDR_LEVEL   = 3'd0;
  localparam logic [2:0] ADDR_CONTROL = 3'd1;
  localparam logic [2:0] ADDR_ACTIVE  = 3'd2;
  localparam logic [2:0] ADDR_GAP     = 3'd3;
  localparam logic [2:0] ADDR_REPEAT  = 3'd4;
  localparam logic [2:0] ADDR_STATUS  = 3'd5;
  localparam int CTRL_START  = 0;
  localparam int CTRL_ABORT  = 1;
  localparam int CTRL_IRQ_EN = 2;
  localparam int STAT_BUSY   = 0;
  localparam int STAT_DONE   = 1;
  localparam int STAT_REM    = 8;
  typedef enum logic [1:0] {IDLE, ACTIVE, GAP} state_t;
endpackage

// File: rtl/gpio_pulse_sequencer_if.sv
// gpio_pulse_sequencer_if: Avalon-MM slave bus of the pulse sequencer
interface gpio_pulse_sequencer_if;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  modport master (output address, chipselect, write_n, writedata, input readdata);
  modport slave  (input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/gpio_seq_timer.sv
// gpio_seq_timer: loadable down-counter with zero flag, holds at zero
module gpio_seq_timer #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);
  logic [W-1:0] cnt;
  always_ff @(posedge clk)
    if (!reset_n) cnt <= '0;
    else if (load) cnt <= load_val;
    else if (!zero) cnt <= cnt - 1'b1;
  assign zero = cnt == '0;
endmodule

// File: rtl/gpio_pulse_sequencer.sv
// gpio_pulse_sequencer: drives one GPIO pin through programmed pulse trains
module gpio_pulse_sequencer
  import gpio_seq_pkg::*;
#(
  parameter int CNT_W = 16,
  parameter int REP_W = 8
) (
  input  logic                    clk,
  input  logic                    reset_n,
  gpio_pulse_sequencer_if.slave   bus,
  output logic                    out_port,
  output logic                    irq
);
  state_t             state, state_nxt;
  logic               level, irq_en, done, done_set, out_nxt, ld, cnt_zero, busy;
  logic [CNT_W-1:0]   active_ticks, gap_ticks, ld_val;
  logic [REP_W-1:0]   rep, remaining, rem_nxt;
  logic               wr, ctrl_wr, start, abort, done_clr, unused_wd;
  function automatic logic [CNT_W-1:0] ticks_m1(input logic [CNT_W-1:0] t);
    return (t == '0) ? '0 : t - 1'b1;
  endfunction
  assign wr        = bus.chipselect & ~bus.write_n;
  assign ctrl_wr   = wr && bus.address == ADDR_CONTROL;
  assign start     = ctrl_wr & bus.writedata[CTRL_START];
  assign abort     = ctrl_wr & bus.writedata[CTRL_ABORT];
  assign done_clr  = wr && bus.address == ADDR_STATUS && bus.writedata[STAT_DONE];
  assign busy      = state != IDLE;
  assign irq       = done & irq_en;
  assign unused_wd = ^bus.writedata;
  gpio_seq_timer #(.W(CNT_W)) u_timer (
    .clk(clk), .reset_n(reset_n), .load(ld), .load_val(ld_val), .zero(cnt_zero)
  );
  always_comb begin
    state_nxt = state;
    out_nxt   = out_port;
    rem_nxt   = remaining;
    ld        = 1'b0;
    ld_val    = ticks_m1(active_ticks);
    done_set  = 1'b0;
    case (state)
      IDLE: begin
        out_nxt = level;
        if (start && !abort && rep != '0) begin
          state_nxt = ACTIVE;
          out_nxt   = ~level;
          ld        = 1'b1;
          rem_nxt   = rep;
        end
      end
      ACTIVE: if (cnt_zero) begin
        out_nxt = level;
        if (remaining > REP_W'(1)) begin
          state_nxt = GAP;
          ld        = 1'b1;
          ld_val    = ticks_m1(gap_ticks);
          rem_nxt   = remaining - 1'b1;
        end else begin
          state_nxt = IDLE;
          rem_nxt   = '0;
          done_set  = 1'b1;
        end
      end
      GAP: if (cnt_zero) begin
        state_nxt = ACTIVE;
        out_nxt   = ~level;
        ld        = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
    // abort overrides whatever the train would have done on this edge, including completion
    if (abort && busy) begin
      state_nxt = IDLE;
      out_nxt   = level;
      rem_nxt   = '0;
      ld        = 1'b0;
      done_set  = 1'b0;
    end
  end
  always_ff @(posedge clk)
    if (!reset_n) state <= IDLE;
    else state <= state_nxt;
  always_ff @(posedge clk)
    if (!reset_n) begin
      level        <= 1'b0;
      irq_en       <= 1'b0;
      active_ticks <= '0;
      gap_ticks    <= '0;
      rep          <= '0;
      remaining    <= '0;
      done         <= 1'b0;
      out_port     <= 1'b0;
    end else begin
      if (wr && !busy && bus.address == ADDR_LEVEL) level <= bus.writedata[0];
      if (wr && !busy && bus.address == ADDR_ACTIVE) active_ticks <= bus.writedata[CNT_W-1:0];
      if (wr && !busy && bus.address == ADDR_GAP) gap_ticks <= bus.writedata[CNT_W-1:0];
      if (wr && !busy && bus.address == ADDR_REPEAT) rep <= bus.writedata[REP_W-1:0];
      if (ctrl_wr) irq_en <= bus.writedata[CTRL_IRQ_EN];
      done      <= done_set | (done & ~done_clr);
      remaining <= rem_nxt;
      out_port  <= out_nxt;
    end
  always_comb begin
    bus.readdata = '0;
    case (bus.address)
      ADDR_LEVEL:   bus.readdata[0] = level;
      ADDR_CONTROL: bus.readdata[CTRL_IRQ_EN] = irq_en;
      ADDR_ACTIVE:  bus.readdata[CNT_W-1:0] = active_ticks;
      ADDR_GAP:     bus.readdata[CNT_W-1:0] = gap_ticks;
      ADDR_REPEAT:  bus.readdata[REP_W-1:0] = rep;
      ADDR_STATUS: begin
        bus.readdata[STAT_BUSY] = busy;
        bus.readdata[STAT_DONE] = done;
        bus.readdata[STAT_REM +: REP_W] = remaining;
      end
      default: bus.readdata = '0;
    endcase
  end
endmodule

// File: tb/tb_gpio_pulse_sequencer.sv
// tb_gpio_pulse_sequencer: table, directed and randomized checks of the pulse sequencer
module tb_gpio_pulse_sequencer;
  import gpio_seq_pkg::*;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic out_port, irq;
  int n_cmp = 0;
  int n_bad = 0;
  gpio_pulse_sequencer_if bus ();
  gpio_pulse_sequencer #(.CNT_W(16), .REP_W(8)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus), .out_port(out_port), .irq(irq)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic [2:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    bus.address = a;
    bus.writedata = d;
    bus.chipselect = 1'b1;
    bus.write_n = 1'b0;
    @(posedge clk);
    #1;
    bus.chipselect = 1'b0;
    bus.write_n = 1'b1;
  endtask
  task automatic rd(input logic [2:0] a, output logic [31:0] d);
    bus.address = a;
    #1;
    d = bus.readdata;
  endtask
  task automatic chk_rd(input string name, input logic [2:0] a, input logic [31:0] exp);
    logic [31:0] d;
    rd(a, d);
    chk(name, d, exp);
  endtask
  vec_t vecs[8];
  initial begin
    logic [31:0] d;
    logic exp_out[8];
    logic lv;
    int a, g, r, len, abort_at;
    bit aborted;
    logic q[$];
    bus.address = '0;
    bus.chipselect = 1'b0;
    bus.write_n = 1'b1;
    bus.writedata = '0;
    cyc();
    cyc();
    reset_n = 1'b1;
    chk("reset out_port", 32'(out_port), 0);
    chk("reset irq", 32'(irq), 0);
    for (int i = 0; i < 8; i++) chk_rd($sformatf("reset reg%0d", i), 3'(i), 0);
    wr(ADDR_CONTROL, 32'h1);
    cyc();
    chk_rd("start rep0 status", ADDR_STATUS, 0);
    // register write/readback; CONTROL first so its START sees REPEAT=0
    vecs[0] = '{ADDR_CONTROL, 32'h0000_0007, 32'h4};
    vecs[1] = '{ADDR_LEVEL,   32'hFFFF_FFFF, 32'h1};
    vecs[2] = '{ADDR_ACTIVE,  32'h0001_2345, 32'h2345};
    vecs[3] = '{ADDR_GAP,     32'hFFFF_ABCD, 32'hABCD};
    vecs[4] = '{ADDR_REPEAT,  32'h0000_01FF, 32'hFF};
    vecs[5] = '{ADDR_STATUS,  32'hFFFF_FFFF, 32'h0};
    vecs[6] = '{3'd6,         32'hFFFF_FFFF, 32'h0};
    vecs[7] = '{3'd7,         32'hFFFF_FFFF, 32'h0};
    foreach (vecs[i]) begin
      wr(vecs[i].addr, vecs[i].wdata);
      chk_rd($sformatf("table reg%0d", vecs[i].addr), vecs[i].addr, vecs[i].exp);
    end
    wr(ADDR_CONTROL, 0);
    chk("level follows out_port", 32'(out_port), 1);
    // LEVEL=1 ACTIVE=3 GAP=2 REPEAT=2
    wr(ADDR_ACTIVE, 3);
    wr(ADDR_GAP, 2);
    wr(ADDR_REPEAT, 2);
    exp_out = '{0, 0, 0, 1, 1, 0, 0, 0};
    wr(ADDR_CONTROL, 1);
    for (int i = 0; i < 8; i++) begin
      if (i > 0) cyc();
      chk($sformatf("train1 out[%0d]", i), 32'(out_port), 32'(exp_out[i]));
    end
    chk_rd("train1 busy before end", ADDR_STATUS, 32'h0000_0101);
    cyc();
    chk("train1 out idle", 32'(out_port), 1);
    chk_rd("train1 done", ADDR_STATUS, 32'h2);
    // zero ticks treated as one
    wr(ADDR_STATUS, 2);
    wr(ADDR_LEVEL, 0);
    wr(ADDR_ACTIVE, 0);
    wr(ADDR_GAP, 0);
    wr(ADDR_REPEAT, 3);
    wr(ADDR_CONTROL, 1);
    for (int i = 0; i < 6; i++) begin
      if (i > 0) cyc();
      chk($sformatf("train2 out[%0d]", i), 32'(out_port), 32'(i % 2 == 0 && i < 5));
      rd(ADDR_STATUS, d);
      chk($sformatf("train2 rem[%0d]", i), 32'(d[15:8]), (i < 5) ? 32'(3 - i / 2 - i % 2) : 0);
    end
    // irq and W1C priority
    wr(ADDR_STATUS, 2);
    wr(ADDR_ACTIVE, 1);
    wr(ADDR_REPEAT, 1);
    wr(ADDR_CONTROL, 32'h5);
    chk("irq low while busy", 32'(irq), 0);
    cyc();
    chk("irq on done", 32'(irq), 1);
    wr(ADDR_STATUS, 2);
    chk("irq after w1c", 32'(irq), 0);
    wr(ADDR_CONTROL, 32'h5);
    wr(ADDR_STATUS, 2);
    chk_rd("set beats w1c", ADDR_STATUS, 32'h2);
    chk("irq after set vs w1c", 32'(irq), 1);
    wr(ADDR_STATUS, 2);
    wr(ADDR_CONTROL, 0);
    // abort mid-train
    wr(ADDR_ACTIVE, 100);
    wr(ADDR_REPEAT, 5);
    wr(ADDR_CONTROL, 1);
    wr(ADDR_ACTIVE, 7);
    for (int i = 2; i < 10; i++) cyc();
    chk_rd("active write ignored", ADDR_ACTIVE, 100);
    chk_rd("busy before abort", ADDR_STATUS, 32'h0000_0501);
    chk("out before abort", 32'(out_port), 1);
    wr(ADDR_CONTROL, 2);
    chk("out after abort", 32'(out_port), 0);
    chk_rd("status after abort", ADDR_STATUS, 0);
    // reset mid-ACTIVE
    wr(ADDR_LEVEL, 1);
    wr(ADDR_ACTIVE, 50);
    wr(ADDR_REPEAT, 2);
    wr(ADDR_CONTROL, 1);
    cyc();
    cyc();
    reset_n = 1'b0;
    cyc();
    chk("out after reset", 32'(out_port), 0);
    chk_rd("status after reset", ADDR_STATUS, 0);
    chk_rd("active after reset", ADDR_ACTIVE, 0);
    chk_rd("level after reset", ADDR_LEVEL, 0);
    reset_n = 1'b1;
    // START with ABORT from idle starts nothing
    wr(ADDR_ACTIVE, 2);
    wr(ADDR_REPEAT, 2);
    wr(ADDR_CONTROL, 3);
    cyc();
    chk_rd("start+abort status", ADDR_STATUS, 0);
    chk("start+abort out", 32'(out_port), 0);
    // randomized trains against an expected-waveform model
    for (int t = 0; t < 25; t++) begin
      lv = 1'($urandom_range(0, 1));
      a = $urandom_range(0, 5);
      g = $urandom_range(0, 5);
      r = $urandom_range(0, 4);
      q.delete();
      for (int p = 0; p < r; p++) begin
        repeat (a == 0 ? 1 : a) q.push_back(~lv);
        if (p < r - 1) repeat (g == 0 ? 1 : g) q.push_back(lv);
      end
      len = q.size();
      abort_at = (t % 3 == 0) ? $urandom_range(1, 45) : 1000;
      aborted = (abort_at <= len);
      wr(ADDR_STATUS, 2);
      wr(ADDR_LEVEL, 32'(lv));
      wr(ADDR_ACTIVE, 32'(a));
      wr(ADDR_GAP, 32'(g));
      wr(ADDR_REPEAT, 32'(r));
      chk($sformatf("rnd%0d idle out", t), 32'(out_port), 32'(lv));
      wr(ADDR_CONTROL, 1);
      for (int i = 0; i <= len + 1; i++) begin
        if (i > 0) begin
          if (i == abort_at) wr(ADDR_CONTROL, 2);
          else cyc();
        end
        chk($sformatf("rnd%0d out[%0d]", t, i), 32'(out_port),
            32'((i < len && !(aborted && i >= abort_at)) ? q[i] : lv));
      end
      rd(ADDR_STATUS, d);
      chk($sformatf("rnd%0d status", t), d, (r != 0 && !aborted) ? 32'h2 : 32'h0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
